// File: rtl/mpl_psum_reader.sv
// mpl_psum_reader: streams psum tiles from SRAM to the max-pool unit in 2x2 pooled order.
module mpl_psum_reader #(
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4:0]               num_tiles,
    output logic                     sram_cen,
    output logic [7:0]               sram_addr,
    input  logic [psum_bw*col-1:0]   sram_rdata,
    output logic [3:0]               order,
    output logic                     enable,
    output logic [psum_bw*col-1:0]   mpl_in,
    output logic [3:0]               mpl_tile,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t     state;
    logic [3:0] tile, cnt, last_tile;
    logic       issue;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tile      <= '0;
            cnt       <= '0;
            last_tile <= '0;
            enable    <= 1'b0;
            mpl_tile  <= '0;
        end else begin
            enable   <= state == ISSUE;
            mpl_tile <= tile;
            case (state)
                IDLE: if (start) begin
                    tile      <= '0;
                    cnt       <= '0;
                    last_tile <= num_tiles >= 5'd16 ? 4'd15 : num_tiles[3:0] - 4'd1;
                    state     <= num_tiles == 5'd0 ? DONE : ISSUE;
                end
                ISSUE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        if (tile == last_tile) state <= DRAIN;
                        else tile <= tile + 4'd1;
                    end
                end
                DRAIN: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    // Bit swap walks each 2x2 window of the 4x4 o_nij grid before moving on.
    assign issue     = state == ISSUE;
    assign sram_cen  = !issue;
    assign order     = issue ? cnt : 4'd0;
    assign sram_addr = issue ? {tile, cnt[3], cnt[1], cnt[2], cnt[0]} : 8'd0;
    assign mpl_in    = sram_rdata;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
endmodule

// File: tb/tb_mpl_psum_reader.sv
// tb_mpl_psum_reader: randomized jobs checked cycle by cycle against a pooled-order reference.
module tb_mpl_psum_reader;
    localparam int W = 128;
    logic         clk = 1'b0;
    logic         reset, start, sram_cen, enable, busy, done;
    logic [4:0]   num_tiles;
    logic [7:0]   sram_addr;
    logic [3:0]   order, mpl_tile;
    logic [W-1:0] sram_rdata, mpl_in;
    logic [W-1:0] mem [256];
    int vectors = 0, errors = 0;

    mpl_psum_reader #(.psum_bw(16), .col(8)) dut (
        .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .order(order), .enable(enable), .mpl_in(mpl_in), .mpl_tile(mpl_tile),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (!sram_cen) sram_rdata <= mem[sram_addr];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // o_nij visited at pooling step o: four 2x2 windows, each row-major, windows row-major.
    function automatic int onij(input int o);
        int g = o / 4, j = o % 4;
        return ((g / 2) * 2 + j / 2) * 4 + (g % 2) * 2 + j % 2;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".cen"}, W'(sram_cen), W'(1));
        chk({tag, ".en"}, W'(enable), W'(0));
        chk({tag, ".busy"}, W'(busy), W'(0));
        chk({tag, ".done"}, W'(done), W'(0));
        chk({tag, ".order"}, W'(order), W'(0));
        chk({tag, ".addr"}, W'(sram_addr), W'(0));
    endtask

    task automatic run_job(input int n, input bit perturb, input int abort_at);
        int nn = n > 16 ? 16 : n;
        int total = nn == 0 ? 1 : 16 * nn + 2;
        int k;
        logic [7:0] ea, prev_ea = '0;
        bit iss;
        @(negedge clk);
        start = 1'b1;
        num_tiles = 5'(n);
        @(negedge clk);
        for (int c = 1; c <= total + 1; c++) begin
            iss = c <= 16 * nn;
            k = c - 1;
            ea = iss ? 8'((k / 16) * 16 + onij(k % 16)) : 8'd0;
            chk("cen", W'(sram_cen), W'(!iss));
            chk("addr", W'(sram_addr), W'(ea));
            chk("order", W'(order), iss ? W'(k % 16) : W'(0));
            chk("en", W'(enable), W'(nn > 0 && c >= 2 && c <= 16 * nn + 1));
            chk("busy", W'(busy), W'(c <= total));
            chk("done", W'(done), W'(c == total));
            if (enable) begin
                chk("mpl_in", mpl_in, mem[prev_ea]);
                chk("mpl_tile", W'(mpl_tile), W'((c - 2) / 16));
            end
            prev_ea = ea;
            if (c == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk_idle("abort");
                chk("abort.tile", W'(mpl_tile), W'(0));
                reset = 1'b0;
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk);
                    chk("abort.nodone", W'(done), W'(0));
                end
                return;
            end
            start = perturb && c <= total ? 1'($urandom) : 1'b0;
            if (perturb) num_tiles = 5'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        reset = 1'b1;
        start = 1'b0;
        num_tiles = 5'd0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset.tile", W'(mpl_tile), W'(0));
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");
        run_job(1, 0, 0);
        run_job(3, 0, 0);
        run_job(0, 0, 0);
        @(negedge clk);
        chk_idle("zero_tiles_idle");
        run_job(2, 1, 0);
        run_job(2, 0, 7);
        run_job(1, 0, 0);
        run_job(20, 0, 0);
        run_job(16, 1, 0);
        for (int j = 0; j < 10; j++) run_job(int'($urandom_range(0, 17)), 1'($urandom), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
